alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Execute-entry stage sitting directly upstream of the ALU.
- Accepts decoded ops from decode over a valid/ready handshake and buffers them in a 2-entry skid queue.
- Resolves operand B as register or immediate and applies writeback forwarding to resident entries.
- Drives operand_a, operand_b and alu_op to the ALU with operand isolation: values hold when idle, so the ALU inputs do not toggle.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.
- OP_W, 6, ALU opcode width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered entries.
- dec_valid  in  1  decode has an op.
- dec_ready  out  1  stage can accept.
- dec_alu_op  in  OP_W  opcode.
- dec_rs1_addr  in  REG_ADDR_W  source 1 index.
- dec_rs2_addr  in  REG_ADDR_W  source 2 index.
- dec_rs1_data  in  XLEN  register file read 1.
- dec_rs2_data  in  XLEN  register file read 2.
- dec_imm  in  XLEN  sign-extended immediate.
- dec_use_imm  in  1  operand B is the immediate.
- dec_rd_addr  in  REG_ADDR_W  destination.
- wb_valid  in  1  writeback occurring.
- wb_rd  in  REG_ADDR_W  writeback destination.
- wb_data  in  XLEN  writeback value.
- ex_valid  out  1  head entry valid for ALU.
- ex_ready  in  1  ALU/execute consumes head.
- operand_a  out  XLEN  ALU operand A.
- operand_b  out  XLEN  ALU operand B.
- alu_op  out  OP_W  ALU opcode.
- ex_rd_addr  out  REG_ADDR_W  destination of head.
- ex_illegal  out  1  head opcode not in supported set.

Behaviour:
- Reset (async, rst_n low): count=0, all entry fields 0. Outputs: dec_ready=1, ex_valid=0, operand_a=0, operand_b=0, alu_op=0, ex_rd_addr=0, ex_illegal=0.
- Storage: 2-entry circular queue with 1-bit head/tail pointers; pointers wrap 1->0.
- Push: dec_valid && dec_ready at a rising edge.
- Pop: ex_valid && ex_ready at a rising edge.
- dec_ready = (count != 2). Derived from registers only; no combinational path from ex_ready.
- ex_valid = (count != 0).
- Latency: an op pushed at edge N is visible on the outputs after edge N.
- Simultaneous push and pop at count=1: count stays 1 and the new entry becomes head.
- At count=2 there is no push. A pop makes dec_ready=1 on the next cycle.
- Pop at count=0 is impossible because ex_valid=0.
- flush: count, head and tail go to 0 on the next edge. flush has priority over push and pop that cycle. Entry data is not cleared, and outputs hold their last values.
- Capture:
  - a_val = forwarded(rs1).
  - b_val = dec_use_imm ? dec_imm : forwarded(rs2).
  - forwarded(x) = wb_data if wb_valid && wb_rd==addr && addr!=0; otherwise the register data.
- Snoop: every cycle, each resident entry with a register-sourced operand whose addr matches wb_rd (nonzero, wb_valid) replaces that operand with wb_data.
  - Applies in the same edge as a pop of that entry (harmless).
  - An immediate-sourced B is never overwritten.
- Outputs are taken from the head entry.
  - When count==0, the head slot is unchanged, so operand_a, operand_b and alu_op hold their last values (operand isolation).
  - ex_valid alone qualifies the outputs.
- ex_illegal = ex_valid && alu_op not in {ADD, SUB, AND, OR, SLL, SRL}. The op is still issued; execute decides how to handle it.
- Arithmetic: none. The stage is a pure pass-through of XLEN bits with no width change.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Defined: capture forwarding and resident snoop as above.
- Undefined: operands are taken raw from dec_rs1_data/dec_rs2_data, there is no snoop, and the wb_* ports exist but are ignored. Decode must then stall on hazards.

Decomposition:
- Package alu_pkg:
  - opcode localparams ALU_ADD=6'b000010, ALU_SUB=6'b000110, ALU_AND=6'b000111, ALU_OR=6'b000101, ALU_SLL=6'b000100, ALU_SRL=6'b000011.
  - OP_W, XLEN defaults.
  - Entry struct typedef: a_val, b_val, a_is_reg, b_is_reg, rs1, rs2, rd, op.
  - Function is_legal_op.
- Sub-module issue_fwd_unit: compare-and-select for one operand, instantiated per operand per entry plus capture.

Test Plan:
- Reset with rst_n low -> ex_valid=0, dec_ready=1, operand_a=0, operand_b=0, alu_op=0.
- Push ADD with rs1_data=100, rs2_data=50, ex_ready=1 -> next cycle operand_a=100, operand_b=50, alu_op=000010, ex_valid=1. Pop -> ex_valid=0 with outputs held at 100/50.
- ex_ready=0, push 3 ops back-to-back -> dec_ready=0 after the 2nd push and the 3rd is not accepted. Release ex_ready -> ops emerge in order, 1 per cycle.
- Forwarding: push SUB with rs1=5, rs1_data=0, same-cycle wb_rd=5, wb_data=7 -> operand_a=7. Resident entry with rs2=6 and later wb_rd=6, wb_data=9 -> operand_b=9. use_imm=1 with imm=1 -> operand_b stays 1 despite a matching wb. wb_rd=0 never forwards.
- flush with count=2 and a simultaneous dec push -> next cycle ex_valid=0, dec_ready=1, and the pushed op is lost.
- Push alu_op=6'b111111 -> ex_illegal=1 while it is head. Push SLL -> ex_illegal=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths and queue entry type for the ALU issue stage
package alu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int OP_W       = 6;

    localparam logic [OP_W-1:0] ALU_ADD = 6'b000010;
    localparam logic [OP_W-1:0] ALU_SUB = 6'b000110;
    localparam logic [OP_W-1:0] ALU_AND = 6'b000111;
    localparam logic [OP_W-1:0] ALU_OR  = 6'b000101;
    localparam logic [OP_W-1:0] ALU_SLL = 6'b000100;
    localparam logic [OP_W-1:0] ALU_SRL = 6'b000011;

    typedef struct packed {
        logic [XLEN-1:0]       a_val;
        logic [XLEN-1:0]       b_val;
        logic                  a_is_reg;
        logic                  b_is_reg;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [OP_W-1:0]       op;
    } entry_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRL: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/issue_fwd_unit.sv
// rtl/issue_fwd_unit.sv - writeback compare-and-select for one operand
// Forwarding is active only when ALU_ISSUE_FWD_EN is defined; otherwise data passes through.
module issue_fwd_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]       data,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       fwd_data
);

`ifdef ALU_ISSUE_FWD_EN
    logic hit;

    // x0 is hardwired zero, so a writeback to it never carries a usable value
    assign hit      = en && wb_valid && (wb_rd == addr) && (addr != '0);
    assign fwd_data = hit ? wb_data : data;
`else
    logic unused_fwd;

    assign unused_fwd = ^{en, addr, wb_valid, wb_rd, wb_data};
    assign fwd_data   = data;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - 2-entry skid queue feeding the ALU with operand isolation
// Writeback forwarding and resident snoop are enabled by ALU_ISSUE_FWD_EN.
module alu_issue_stage import alu_pkg::*; #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OP_W       = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [OP_W-1:0]       dec_alu_op,
    input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
    input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
    input  logic [XLEN-1:0]       dec_rs1_data,
    input  logic [XLEN-1:0]       dec_rs2_data,
    input  logic [XLEN-1:0]       dec_imm,
    input  logic                  dec_use_imm,
    input  logic [REG_ADDR_W-1:0] dec_rd_addr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       operand_a,
    output logic [XLEN-1:0]       operand_b,
    output logic [OP_W-1:0]       alu_op,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_illegal
);

    entry_t                q [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            count;
    logic                  push;
    logic                  pop;
    logic [XLEN-1:0]       cap_a;
    logic [XLEN-1:0]       cap_b_fwd;
    entry_t                new_entry;
    logic [XLEN-1:0]       snp_a [2];
    logic [XLEN-1:0]       snp_b [2];
    logic [1:0]            resident;
    logic [XLEN-1:0]       hold_a;
    logic [XLEN-1:0]       hold_b;
    logic [OP_W-1:0]       hold_op;
    logic [REG_ADDR_W-1:0] hold_rd;

    assign dec_ready = (count != 2'd2);
    assign ex_valid  = (count != 2'd0);
    assign push      = dec_valid && dec_ready;
    assign pop       = ex_valid && ex_ready;

    issue_fwd_unit #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_cap_a (
        .en(1'b1), .addr(dec_rs1_addr), .data(dec_rs1_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_data(cap_a)
    );

    issue_fwd_unit #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_cap_b (
        .en(!dec_use_imm), .addr(dec_rs2_addr), .data(dec_rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_data(cap_b_fwd)
    );

    always_comb begin
        new_entry          = '0;
        new_entry.a_val    = cap_a;
        new_entry.b_val    = dec_use_imm ? dec_imm : cap_b_fwd;
        new_entry.a_is_reg = 1'b1;
        new_entry.b_is_reg = !dec_use_imm;
        new_entry.rs1      = dec_rs1_addr;
        new_entry.rs2      = dec_rs2_addr;
        new_entry.rd       = dec_rd_addr;
        new_entry.op       = dec_alu_op;
    end

    for (genvar g = 0; g < 2; g++) begin : g_snoop
        // Only live slots are snooped so an idle head slot never changes under the ALU
        assign resident[g] = (count == 2'd2) || ((count == 2'd1) && (head == 1'(g)));

        issue_fwd_unit #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_snp_a (
            .en(q[g].a_is_reg), .addr(q[g].rs1), .data(q[g].a_val),
            .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_data(snp_a[g])
        );

        issue_fwd_unit #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_snp_b (
            .en(q[g].b_is_reg), .addr(q[g].rs2), .data(q[g].b_val),
            .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_data(snp_b[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            head    <= 1'b0;
            tail    <= 1'b0;
            q[0]    <= '0;
            q[1]    <= '0;
            hold_a  <= '0;
            hold_b  <= '0;
            hold_op <= '0;
            hold_rd <= '0;
        end else begin
            // Last driven values, replayed whenever the queue is empty
            hold_a  <= operand_a;
            hold_b  <= operand_b;
            hold_op <= alu_op;
            hold_rd <= ex_rd_addr;
            if (flush) begin
                count <= 2'd0;
                head  <= 1'b0;
                tail  <= 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (resident[i]) begin
                        q[i].a_val <= snp_a[i];
                        q[i].b_val <= snp_b[i];
                    end
                end
                if (push) begin
                    q[tail] <= new_entry;
                    tail    <= ~tail;
                end
                if (pop) begin
                    head <= ~head;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign operand_a  = ex_valid ? q[head].a_val : hold_a;
    assign operand_b  = ex_valid ? q[head].b_val : hold_b;
    assign alu_op     = ex_valid ? q[head].op    : hold_op;
    assign ex_rd_addr = ex_valid ? q[head].rd    : hold_rd;
    assign ex_illegal = ex_valid && !is_legal_op(alu_op);

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [5:0]  dec_alu_op;
    logic [4:0]  dec_rs1_addr;
    logic [4:0]  dec_rs2_addr;
    logic [31:0] dec_rs1_data;
    logic [31:0] dec_rs2_data;
    logic [31:0] dec_imm;
    logic        dec_use_imm;
    logic [4:0]  dec_rd_addr;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [5:0]  alu_op;
    logic [4:0]  ex_rd_addr;
    logic        ex_illegal;

    int n_cmp;
    int n_err;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_alu_op(dec_alu_op),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
        .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_rd_addr(dec_rd_addr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
        .ex_rd_addr(ex_rd_addr), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic ui, input logic [4:0] rd);
        dec_valid    = 1'b1;
        dec_alu_op   = op;
        dec_rs1_addr = r1;
        dec_rs2_addr = r2;
        dec_rs1_data = d1;
        dec_rs2_data = d2;
        dec_imm      = imm;
        dec_use_imm  = ui;
        dec_rd_addr  = rd;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
        dec_valid = 1'b0;
        push_op(6'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        dec_valid = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        #12;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_dec_ready", 32'(dec_ready), 32'd1);
        check("rst_operand_a", operand_a, 32'd0);
        check("rst_operand_b", operand_b, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_illegal", 32'(ex_illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single ADD, consumed immediately
        ex_ready = 1'b1;
        push_op(6'b000010, 5'd1, 5'd2, 32'd100, 32'd50, 32'd0, 1'b0, 5'd3);
        tick();
        dec_valid = 1'b0;
        check("add_valid", 32'(ex_valid), 32'd1);
        check("add_a", operand_a, 32'd100);
        check("add_b", operand_b, 32'd50);
        check("add_op", 32'(alu_op), 32'b000010);
        check("add_rd", 32'(ex_rd_addr), 32'd3);
        tick();
        check("pop_valid", 32'(ex_valid), 32'd0);
        check("hold_a", operand_a, 32'd100);
        check("hold_b", operand_b, 32'd50);

        // fill with execute stalled; third op must be refused
        ex_ready = 1'b0;
        push_op(6'b000111, 5'd1, 5'd2, 32'd11, 32'd12, 32'd0, 1'b0, 5'd1);
        tick();
        check("fill1_ready", 32'(dec_ready), 32'd1);
        push_op(6'b000101, 5'd1, 5'd2, 32'd21, 32'd22, 32'd0, 1'b0, 5'd2);
        tick();
        check("fill2_ready", 32'(dec_ready), 32'd0);
        push_op(6'b000110, 5'd1, 5'd2, 32'd31, 32'd32, 32'd0, 1'b0, 5'd4);
        tick();
        check("fill3_ready", 32'(dec_ready), 32'd0);
        check("fill3_head_a", operand_a, 32'd11);
        check("fill3_head_op", 32'(alu_op), 32'b000111);
        dec_valid = 1'b0;
        ex_ready = 1'b1;
        tick();
        check("drain1_a", operand_a, 32'd21);
        check("drain1_op", 32'(alu_op), 32'b000101);
        check("drain1_ready", 32'(dec_ready), 32'd1);
        tick();
        check("drain2_valid", 32'(ex_valid), 32'd0);
        check("drain2_hold_a", operand_a, 32'd21);

        // capture-time forwarding and resident snoop
        ex_ready = 1'b0;
        push_op(6'b000110, 5'd5, 5'd6, 32'd0, 32'd4, 32'd0, 1'b0, 5'd7);
        set_wb(1'b1, 5'd5, 32'd7);
        tick();
        dec_valid = 1'b0;
        check("fwd_cap_a", operand_a, FWD ? 32'd7 : 32'd0);
        check("fwd_cap_b", operand_b, 32'd4);
        set_wb(1'b1, 5'd6, 32'd9);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        check("snoop_b", operand_b, FWD ? 32'd9 : 32'd4);
        check("snoop_a_kept", operand_a, FWD ? 32'd7 : 32'd0);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        check("fwd_drained", 32'(ex_valid), 32'd0);

        // immediate B and x0 are never overwritten
        push_op(6'b000010, 5'd0, 5'd8, 32'd3, 32'd20, 32'd1, 1'b1, 5'd9);
        set_wb(1'b1, 5'd0, 32'd55);
        tick();
        dec_valid = 1'b0;
        check("x0_cap_a", operand_a, 32'd3);
        check("imm_cap_b", operand_b, 32'd1);
        set_wb(1'b1, 5'd8, 32'd66);
        tick();
        check("imm_snoop_b", operand_b, 32'd1);
        set_wb(1'b1, 5'd0, 32'd77);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        check("x0_snoop_a", operand_a, 32'd3);
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;

        // flush when full, with decode still offering an op
        push_op(6'b000010, 5'd1, 5'd2, 32'd41, 32'd42, 32'd0, 1'b0, 5'd1);
        tick();
        push_op(6'b000010, 5'd1, 5'd2, 32'd51, 32'd52, 32'd0, 1'b0, 5'd2);
        tick();
        check("pre_flush_ready", 32'(dec_ready), 32'd0);
        push_op(6'b000010, 5'd1, 5'd2, 32'd61, 32'd62, 32'd0, 1'b0, 5'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dec_valid = 1'b0;
        check("flush2_valid", 32'(ex_valid), 32'd0);
        check("flush2_ready", 32'(dec_ready), 32'd1);
        check("flush2_hold_a", operand_a, 32'd41);
        tick();
        check("flush2_lost", 32'(ex_valid), 32'd0);

        // flush beats a push that would otherwise be accepted
        push_op(6'b000010, 5'd1, 5'd2, 32'd71, 32'd72, 32'd0, 1'b0, 5'd4);
        tick();
        push_op(6'b000010, 5'd1, 5'd2, 32'd81, 32'd82, 32'd0, 1'b0, 5'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dec_valid = 1'b0;
        check("flush1_valid", 32'(ex_valid), 32'd0);
        check("flush1_hold_a", operand_a, 32'd71);
        tick();
        check("flush1_lost", 32'(ex_valid), 32'd0);

        // illegal detection, plus simultaneous push/pop at one entry
        push_op(6'b111111, 5'd1, 5'd2, 32'd91, 32'd92, 32'd0, 1'b0, 5'd6);
        tick();
        check("illegal_set", 32'(ex_illegal), 32'd1);
        ex_ready = 1'b1;
        push_op(6'b000100, 5'd1, 5'd2, 32'd101, 32'd102, 32'd0, 1'b0, 5'd7);
        tick();
        check("sll_valid", 32'(ex_valid), 32'd1);
        check("sll_ready", 32'(dec_ready), 32'd1);
        check("sll_a", operand_a, 32'd101);
        check("sll_op", 32'(alu_op), 32'b000100);
        check("sll_illegal", 32'(ex_illegal), 32'd0);
        push_op(6'b111111, 5'd1, 5'd2, 32'd111, 32'd112, 32'd0, 1'b0, 5'd8);
        tick();
        check("illegal2_set", 32'(ex_illegal), 32'd1);
        dec_valid = 1'b0;
        tick();
        check("idle_valid", 32'(ex_valid), 32'd0);
        check("idle_hold_op", 32'(alu_op), 32'b111111);
        check("idle_illegal", 32'(ex_illegal), 32'd0);
        ex_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
